// File: rtl/ofdm_dout_byte_serializer.sv
// ofdm_dout_byte_serializer
// Buffers 48-bit decoder words in a small FIFO and replays each word as a
// sequence of bytes, most significant byte first, on a valid/ready stream.
// Words pushed while the FIFO is full (and nothing leaves that cycle) are
// dropped and reported through a sticky Overflow flag.
module ofdm_dout_byte_serializer #(
    parameter int WORD_W = 48,
    parameter int BYTE_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     PushOut,
    input  logic [WORD_W-1:0]        DataOut,
    output logic                     ByteValid,
    input  logic                     ByteReady,
    output logic [BYTE_W-1:0]        ByteData,
    output logic                     LastByte,
    output logic                     Overflow,
    output logic [$clog2(DEPTH):0]   Level
);

    localparam int NBYTES = WORD_W / BYTE_W;
    localparam int AW     = $clog2(DEPTH);
    localparam int LW     = AW + 1;
    localparam int CW     = $clog2(NBYTES);

    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                state_r, state_s;
    logic [WORD_W-1:0]     mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]         level_r;
    logic                  ovf_r;
    logic [WORD_W-1:0]     shift_r, shift_s;
    logic [CW-1:0]         idx_r, idx_s;
    logic                  valid_r, valid_s;
    logic                  last_r, last_s;
    logic                  pop_s, wr_s, full_s, nempty_s, fire_s;
    logic [WORD_W-1:0]     head_s;

    // FIFO status, write qualification and byte handshake decode
    always_comb begin
        full_s   = (level_r == FULL_LVL);
        nempty_s = (level_r != {LW{1'b0}});
        wr_s     = PushOut & (~full_s | pop_s);
        head_s   = mem_r[rd_ptr_r];
        fire_s   = valid_r & ByteReady;
    end

    // FIFO storage; no reset needed because Level gates every read
    always_ff @(posedge Clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= DataOut;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
            if (PushOut && full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Serializer state register and registered byte-stream outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            shift_r <= {WORD_W{1'b0}};
            idx_r   <= {CW{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            idx_r   <= idx_s;
            valid_r <= valid_s;
            last_r  <= last_s;
        end
    end

    // Next-state logic: load a word from the FIFO, step one byte per fire,
    // chain straight into the next word when one is waiting
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        idx_s   = idx_r;
        valid_s = valid_r;
        last_s  = last_r;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                valid_s = 1'b0;
                last_s  = 1'b0;
                if (nempty_s) begin
                    pop_s   = 1'b1;
                    shift_s = head_s;
                    idx_s   = LAST_IDX;
                    valid_s = 1'b1;
                    last_s  = (LAST_IDX == {CW{1'b0}});
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!fire_s) begin
                    // stalled: every output register holds its value
                    state_s = ST_SHIFT;
                end else if (idx_r != {CW{1'b0}}) begin
                    shift_s = shift_r << BYTE_W;
                    idx_s   = idx_r - CW'(1);
                    last_s  = (idx_r == CW'(1));
                end else if (nempty_s) begin
                    pop_s   = 1'b1;
                    shift_s = head_s;
                    idx_s   = LAST_IDX;
                    valid_s = 1'b1;
                    last_s  = (LAST_IDX == {CW{1'b0}});
                end else begin
                    shift_s = shift_r << BYTE_W;
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                last_s  = 1'b0;
            end
        endcase
    end

    assign ByteValid = valid_r;
    assign ByteData  = shift_r[WORD_W-1 -: BYTE_W];
    assign LastByte  = last_r;
    assign Overflow  = ovf_r;
    assign Level     = level_r;

endmodule

// File: tb/tb_ofdm_dout_byte_serializer.sv
// Directed, table-driven bench for ofdm_dout_byte_serializer.
// Each table row gives the inputs for one cycle and the outputs expected
// in the following cycle; multi-cycle corner cases are written out by hand.
module tb_ofdm_dout_byte_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [47:0] data;
    logic        ready;
    logic        bvalid;
    logic [7:0]  bdata;
    logic        blast;
    logic        ovf;
    logic [2:0]  level;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        push;
        logic [47:0] data;
        logic        ready;
        logic        ev;
        logic [7:0]  eb;
        logic        el;
        logic [2:0]  elv;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    ofdm_dout_byte_serializer #(.WORD_W(48), .BYTE_W(8), .DEPTH(4)) dut (
        .Clk       (clk),
        .Reset     (reset),
        .PushOut   (push),
        .DataOut   (data),
        .ByteValid (bvalid),
        .ByteReady (ready),
        .ByteData  (bdata),
        .LastByte  (blast),
        .Overflow  (ovf),
        .Level     (level)
    );

    always #5 clk = ~clk;

    // advance one cycle and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic p, input logic [47:0] d, input logic rdy,
                       input logic ev, input logic [7:0] eb, input logic el,
                       input logic [2:0] elv, input logic eo);
        vec_t v;
        v.rst = rst; v.push = p; v.data = d; v.ready = rdy;
        v.ev = ev; v.eb = eb; v.el = el; v.elv = elv; v.eo = eo;
        vecs.push_back(v);
    endtask

    // byte p of the overflow stream: word p/6, byte p%6 -> {A+w, b}
    function automatic logic [7:0] ovf_byte(input int p);
        return {4'(10 + p / 6), 4'(p % 6)};
    endfunction

    function automatic logic [47:0] ovf_word(input int w);
        logic [47:0] r;
        r = 48'h0;
        for (int b = 0; b < 6; b++) begin
            r[47 - 8*b -: 8] = ovf_byte(w * 6 + b);
        end
        return r;
    endfunction

    initial begin
        logic [47:0] sw;
        logic [47:0] wx;
        logic [47:0] wy;
        logic [47:0] wz;
        logic [47:0] hist;
        logic [7:0]  cap_b [8];
        logic        cap_l [8];
        logic        pv, pl, pr;
        logic [7:0]  pb;
        logic        seen;
        int          nf;

        sw = 48'h0123456789AB;
        wx = 48'h5A5A0F0FC3C3;
        wy = 48'hCAFEBABE1234;
        wz = 48'h13579BDF2468;

        // single word, ByteReady held high
        add(1'b0, 1'b1, sw, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0);
        for (int b = 0; b < 6; b++) begin
            add(1'b0, 1'b0, 48'h0, 1'b1, 1'b1, sw[47 - 8*b -: 8], (b == 5), 3'd0, 1'b0);
        end
        add(1'b0, 1'b0, 48'h0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

        // back-to-back words A then B, no bubble
        add(1'b0, 1'b1, 48'h111111111111, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0);
        add(1'b0, 1'b1, 48'h222222222222, 1'b1, 1'b1, 8'h11, 1'b0, 3'd1, 1'b0);
        for (int b = 1; b < 6; b++) begin
            add(1'b0, 1'b0, 48'h0, 1'b1, 1'b1, 8'h11, (b == 5), 3'd1, 1'b0);
        end
        for (int b = 0; b < 6; b++) begin
            add(1'b0, 1'b0, 48'h0, 1'b1, 1'b1, 8'h22, (b == 5), 3'd0, 1'b0);
        end
        add(1'b0, 1'b0, 48'h0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

        // overflow: six pushes with consumer stalled, W5 dropped
        add(1'b0, 1'b1, ovf_word(0), 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0);
        add(1'b0, 1'b1, ovf_word(1), 1'b0, 1'b1, 8'hA0, 1'b0, 3'd1, 1'b0);
        add(1'b0, 1'b1, ovf_word(2), 1'b0, 1'b1, 8'hA0, 1'b0, 3'd2, 1'b0);
        add(1'b0, 1'b1, ovf_word(3), 1'b0, 1'b1, 8'hA0, 1'b0, 3'd3, 1'b0);
        add(1'b0, 1'b1, ovf_word(4), 1'b0, 1'b1, 8'hA0, 1'b0, 3'd4, 1'b0);
        add(1'b0, 1'b1, ovf_word(5), 1'b0, 1'b1, 8'hA0, 1'b0, 3'd4, 1'b1);
        add(1'b0, 1'b0, 48'h0,       1'b0, 1'b1, 8'hA0, 1'b0, 3'd4, 1'b1);
        for (int p = 1; p < 30; p++) begin
            add(1'b0, 1'b0, 48'h0, 1'b1, 1'b1, ovf_byte(p), ((p % 6) == 5), 3'(4 - p / 6), 1'b1);
        end
        add(1'b0, 1'b0, 48'h0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
        add(1'b1, 1'b0, 48'h0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

        // reset state
        reset = 1'b1; push = 1'b0; data = 48'h0; ready = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(bvalid), 64'h0);
        chk("rst_data",  64'(bdata),  64'h0);
        chk("rst_last",  64'(blast),  64'h0);
        chk("rst_ovf",   64'(ovf),    64'h0);
        chk("rst_level", 64'(level),  64'h0);
        reset = 1'b0;

        // table
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; push = vecs[i].push; data = vecs[i].data; ready = vecs[i].ready;
            step();
            chk($sformatf("vec%0d_valid", i), 64'(bvalid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d_level", i), 64'(level),  64'(vecs[i].elv));
            chk($sformatf("vec%0d_ovf",   i), 64'(ovf),    64'(vecs[i].eo));
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_byte", i), 64'(bdata), 64'(vecs[i].eb));
                chk($sformatf("vec%0d_last", i), 64'(blast), 64'(vecs[i].el));
            end
        end
        reset = 1'b0; push = 1'b0; ready = 1'b0;

        // back-pressure: ready pattern 1,0,0 repeating
        push = 1'b1; data = sw;
        step();
        push = 1'b0;
        nf = 0;
        for (int c = 0; c < 40; c++) begin
            ready = ((c % 3) == 0);
            pv = bvalid; pb = bdata; pl = blast; pr = ready;
            if (pv && pr) begin
                if (nf < 8) begin
                    cap_b[nf] = pb;
                    cap_l[nf] = pl;
                end
                nf++;
            end
            step();
            if (pv && !pr) begin
                chk($sformatf("bp_hold_valid_c%0d", c), 64'(bvalid), 64'h1);
                chk($sformatf("bp_hold_byte_c%0d",  c), 64'(bdata),  64'(pb));
                chk($sformatf("bp_hold_last_c%0d",  c), 64'(blast),  64'(pl));
            end
        end
        chk("bp_fires", 64'(nf), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < nf) begin
                chk($sformatf("bp_byte%0d", i), 64'(cap_b[i]), 64'(sw[47 - 8*i -: 8]));
                chk($sformatf("bp_last%0d", i), 64'(cap_l[i]), 64'(i == 5));
            end
        end
        ready = 1'b0;

        // push while full with a pop in the same cycle
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int w = 0; w < 5; w++) begin
            push = 1'b1; data = ovf_word(w);
            step();
        end
        push = 1'b0; ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            step();
        end
        chk("pf_on_last",   64'(blast), 64'h1);
        chk("pf_last_byte", 64'(bdata), 64'hA5);
        chk("pf_level_pre", 64'(level), 64'd4);
        push = 1'b1; data = wx;
        step();
        push = 1'b0;
        chk("pf_level", 64'(level),  64'd4);
        chk("pf_ovf",   64'(ovf),    64'h0);
        chk("pf_valid", 64'(bvalid), 64'h1);
        chk("pf_next",  64'(bdata),  64'hB0);
        nf = 0;
        hist = 48'h0;
        for (int c = 0; c < 60; c++) begin
            if (bvalid) begin
                nf++;
                hist = {hist[39:0], bdata};
            end
            step();
        end
        chk("pf_drain_count", 64'(nf),   64'd30);
        chk("pf_last_word",   64'(hist), 64'(wx));
        chk("pf_ovf_end",     64'(ovf),  64'h0);

        // reset in the middle of a word
        reset = 1'b1;
        step();
        reset = 1'b0;
        push = 1'b1; data = wy; ready = 1'b1;
        step();
        push = 1'b0;
        step();
        step();
        step();
        step();
        chk("rm_byte3", 64'(bdata), 64'(wy[23:16]));
        reset = 1'b1; ready = 1'b0;
        step();
        reset = 1'b0; ready = 1'b1;
        chk("rm_valid", 64'(bvalid), 64'h0);
        chk("rm_level", 64'(level),  64'd0);
        chk("rm_ovf",   64'(ovf),    64'h0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            seen = seen | bvalid;
        end
        chk("rm_no_residue", 64'(seen), 64'h0);
        push = 1'b1; data = wz;
        step();
        push = 1'b0;
        chk("rm_lat1_valid", 64'(bvalid), 64'h0);
        chk("rm_lat1_level", 64'(level),  64'd1);
        for (int b = 0; b < 6; b++) begin
            step();
            chk($sformatf("rm_z_valid%0d", b), 64'(bvalid), 64'h1);
            chk($sformatf("rm_z_byte%0d",  b), 64'(bdata),  64'(wz[47 - 8*b -: 8]));
            chk($sformatf("rm_z_last%0d",  b), 64'(blast),  64'(b == 5));
        end
        step();
        chk("rm_z_end", 64'(bvalid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ofdm_dout_byte_serializer.md
Name: ofdm_dout_byte_serializer

Overview:
Downstream consumer of the OFDM decoder's output push bus (PushOut / 48-bit DataOut). It buffers decoded 48-bit words in a small FIFO and emits each word as six bytes, MSB first, on a valid/ready byte stream toward the host/packet interface. It absorbs decoder bursts, applies back-pressure-tolerant buffering, and flags lost words.

Parameters:
WORD_W, 48, decoded word width; must be a multiple of BYTE_W
BYTE_W, 8, output byte width
DEPTH, 4, FIFO depth in words; power of 2, >= 2

Ports:
Clk  input  1  system clock; all logic on rising edge
Reset  input  1  synchronous, active-high reset
PushOut  input  1  decoder word strobe; one word per cycle while high
DataOut  input  WORD_W  decoded word, valid when PushOut=1
ByteValid  output  1  ByteData/LastByte valid
ByteReady  input  1  consumer accepts byte when ByteValid & ByteReady
ByteData  output  BYTE_W  current byte
LastByte  output  1  high with final byte (bits 7:0) of a word
Overflow  output  1  sticky; a pushed word was dropped
Level  output  $clog2(DEPTH)+1  words held in FIFO (excludes word in shift register)

Behaviour:
- Interface decided: one clock Clk; Reset synchronous, active-high.
- Reset (sampled at rising edge): FIFO emptied, pointers 0, Level=0, ByteValid=0, ByteData=0, LastByte=0, Overflow=0, FSM->IDLE. Reset mid-word discards the partial word; no further bytes of it are emitted.
- Byte fire = ByteValid & ByteReady. NBYTES = WORD_W/BYTE_W (6).
- FIFO write: PushOut & (!full | pop_this_cycle). Full with no pop that cycle -> word dropped, Overflow<=1, held until Reset. Level updates by +1 / -1 / 0 on write-only / pop-only / both.
- FIFO pop: occurs when the FSM loads the shift register (below). Pop of an empty FIFO never occurs.
- FSM states:
  IDLE: ByteValid=0. If FIFO non-empty: pop head into shift register, byte index<=NBYTES-1, ->SHIFT.
  SHIFT: ByteValid=1, ByteData = shift_reg[idx*BYTE_W +: BYTE_W] (idx=5 first, i.e. bits 47:40), LastByte=(idx==0).
   - no fire: all outputs held stable (no change of ByteData/LastByte while stalled).
   - fire, idx>0: idx<=idx-1.
   - fire, idx==0, FIFO non-empty: pop next word, idx<=NBYTES-1, stay SHIFT (no bubble between words).
   - fire, idx==0, FIFO empty: ->IDLE, ByteValid<=0.
- FIFO non-empty test uses registered Level (word written at edge t is visible in cycle t+1; no write-to-read bypass).
- Latency: PushOut at cycle t into empty block with ByteReady=1 -> first byte ByteValid in cycle t+2; last byte in cycle t+7.
- Sustained throughput: 1 word / NBYTES cycles; decoder bursts above that rate are absorbed up to DEPTH words plus the word in the shift register.
- Level never exceeds DEPTH; words exit in push order.

Test Plan:
- Single word: Reset, push 0x0123_4567_89AB at t, ByteReady=1 -> bytes 01,23,45,67,89,AB in cycles t+2..t+7, LastByte only with AB, ByteValid=0 at t+8, Level back to 0.
- Back-pressure: same word, ByteReady toggled 1,0,0,1,... -> ByteData/LastByte held constant during stalls, byte sequence unchanged, exactly 6 fires.
- Back-to-back: push words A=0x111111111111, B=0x222222222222 on consecutive cycles, ByteReady=1 -> 12 contiguous valid cycles, LastByte at 6th and 12th, no bubble between A and B.
- Overflow: ByteReady=0, push 6 words W0..W5 consecutively -> W0 in shift reg, W1..W4 in FIFO (Level=4), W5 dropped, Overflow=1 sticky; release ready -> W0..W4 emitted in order, Overflow stays 1 until Reset.
- Push while full with pop: FIFO full, shift reg on last byte, ByteReady=1 and PushOut same cycle -> new word accepted, Overflow stays 0, Level stays 4.
- Reset mid-word: after 3 bytes of a word fire, assert Reset one cycle -> next cycle ByteValid=0, Level=0, Overflow=0; no remaining bytes of that word appear; next pushed word serializes normally with 2-cycle latency.
